// File: rtl/b10_link_arbiter.sv
// ---------------------------------------------------------------------------
// b10_link_arbiter
//   Round-robin arbiter plus rts/cts four-phase handshake sequencer that
//   shares one b10-style serial link among N_REQ requesters. The winner's
//   value is latched onto o_v_out, rts is raised until cts is seen, dropped
//   until cts clears, and a one-cycle ack is returned to the winner.
//
// Optional feature macro: LINK_ARB_TIMEOUT_EN
//   When defined, SEND and RELEASE abort after TIMEOUT_CYC cycles through a
//   one-cycle ABORT state that pulses o_err. When undefined, o_err is tied 0
//   and the handshake waits indefinitely.
//
// Ports
//   i_clock     system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_req       per-requester level request, held with data until ack/err
//   i_req_data  packed values, requester i at [i*DW +: DW]
//   o_ack       one-cycle completion pulse to the granted requester
//   o_err       one-cycle abort pulse (timeout build only, else 0)
//   o_rts       request-to-send toward the link
//   i_cts       clear-to-send from the link (synchronous to i_clock)
//   o_v_out     value presented on the link
//   o_busy      high in every state except IDLE
//   o_grant_id  index of the current/last granted requester
// ---------------------------------------------------------------------------
module b10_link_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW          = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*DW-1:0]   i_req_data,
  output logic [N_REQ-1:0]      o_ack,
  output logic [N_REQ-1:0]      o_err,
  output logic                  o_rts,
  input  logic                  i_cts,
  output logic [DW-1:0]         o_v_out,
  output logic                  o_busy,
  output logic [GW-1:0]         o_grant_id
);

`ifdef LINK_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_RELEASE = 3'd2,
    S_DONE    = 3'd3,
    S_ABORT   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_RELEASE = 3'd2,
    S_DONE    = 3'd3
  } state_t;
`endif

  // (base + step) mod N_REQ, with step in 1..N_REQ so one subtraction suffices.
  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return GW'(sum);
  endfunction

  state_t                r_state, w_state_next;
  logic                  r_rts, w_rts_next;
  logic [DW-1:0]         r_v_out, w_v_out_next;
  logic [N_REQ-1:0]      r_ack, w_ack_next;
  logic                  r_busy, w_busy_next;
  logic [GW-1:0]         r_grant_id, w_grant_id_next;
  logic [GW-1:0]         r_last, w_last_next;

  logic [N_REQ-1:0]      w_rot_req;
  logic [DW-1:0]         w_data_arr [N_REQ];
  logic [GW-1:0]         w_offset;
  logic [GW-1:0]         w_winner;

  // w_rot_req[k] is the request of the requester k+1 places after r_last,
  // so the lowest set bit is the round-robin winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign w_rot_req[gi]  = i_req[rr_index(r_last, gi + 1)];
      assign w_data_arr[gi] = i_req_data[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    w_offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot_req[k]) w_offset = GW'(k);
    end
  end

  assign w_winner = rr_index(r_last, int'(w_offset) + 1);

`ifdef LINK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic [N_REQ-1:0] r_err, w_err_next;
  logic             w_expired;

  assign w_cnt_inc = r_cnt + CW'(1);
  // This wait cycle would be the TIMEOUT_CYC-th one spent in the state.
  assign w_expired = (w_cnt_inc == CW'(TIMEOUT_CYC));
`endif

  always_comb begin
    w_state_next    = r_state;
    w_rts_next      = r_rts;
    w_v_out_next    = r_v_out;
    w_grant_id_next = r_grant_id;
    w_last_next     = r_last;
    w_ack_next      = '0;
`ifdef LINK_ARB_TIMEOUT_EN
    w_err_next      = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_grant_id_next = w_winner;
          w_last_next     = w_winner;
          w_v_out_next    = w_data_arr[w_winner];
          w_rts_next      = 1'b1;
          w_state_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (i_cts) begin
          w_rts_next   = 1'b0;
          w_state_next = S_RELEASE;
        end
`ifdef LINK_ARB_TIMEOUT_EN
        else if (w_expired) begin
          w_rts_next               = 1'b0;
          w_err_next[r_grant_id]   = 1'b1;
          w_state_next             = S_ABORT;
        end
`endif
      end
      S_RELEASE: begin
        if (!i_cts) begin
          w_ack_next[r_grant_id] = 1'b1;
          w_state_next           = S_DONE;
        end
`ifdef LINK_ARB_TIMEOUT_EN
        else if (w_expired) begin
          w_err_next[r_grant_id] = 1'b1;
          w_state_next           = S_ABORT;
        end
`endif
      end
      S_DONE: w_state_next = S_IDLE;
`ifdef LINK_ARB_TIMEOUT_EN
      S_ABORT: w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase

`ifdef LINK_ARB_TIMEOUT_EN
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (r_state == S_SEND || r_state == S_RELEASE) begin
      w_cnt_next = w_cnt_inc;
    end else begin
      w_cnt_next = r_cnt;
    end
`endif
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rts      <= 1'b0;
      r_v_out    <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_last     <= GW'(N_REQ - 1);
`ifdef LINK_ARB_TIMEOUT_EN
      r_err      <= '0;
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_rts      <= w_rts_next;
      r_v_out    <= w_v_out_next;
      r_ack      <= w_ack_next;
      r_busy     <= w_busy_next;
      r_grant_id <= w_grant_id_next;
      r_last     <= w_last_next;
`ifdef LINK_ARB_TIMEOUT_EN
      r_err      <= w_err_next;
      r_cnt      <= w_cnt_next;
`endif
    end
  end

  assign o_rts      = r_rts;
  assign o_v_out    = r_v_out;
  assign o_ack      = r_ack;
  assign o_busy     = r_busy;
  assign o_grant_id = r_grant_id;
`ifdef LINK_ARB_TIMEOUT_EN
  assign o_err      = r_err;
`else
  assign o_err      = '0;
`endif

endmodule

// File: tb/tb_b10_link_arbiter.sv
module tb_b10_link_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            cts = 1'b0;
  logic [N-1:0]    ack, err;
  logic            rts;
  logic [DW-1:0]   v_out;
  logic            busy;
  logic [GW-1:0]   grant_id;

  b10_link_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_err(err), .o_rts(rts), .i_cts(cts),
    .o_v_out(v_out), .o_busy(busy), .o_grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int data; bit is_err; } exp_t;
  typedef struct { string name; int got; int want; } dchk_t;

  exp_t  exp_q[$];
  dchk_t dq[$];
  int    ack_log[$];
  int    total = 0;
  int    bad = 0;

  // ---------------- reference model (transaction phases) ----------------
  // 0 idle, 1 waiting for cts high, 2 waiting for cts low, 3 ack cycle, 4 err cycle
  int m_phase = 0;
  int m_last = N - 1;
  int m_cnt = 0;
  int m_id = 0;
  int m_data = 0;
  int m_w, m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_last  = N - 1;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          m_w = -1;
          for (int k = 1; k <= N; k++) begin
            m_idx = (m_last + k) % N;
            if (m_w < 0 && ((req >> m_idx) & N'(1)) != '0) m_w = m_idx;
          end
          m_id    = m_w;
          m_data  = int'(DW'(req_data >> (m_w * DW)));
          m_last  = m_w;
          m_phase = 1;
          m_cnt   = 0;
        end
        1: if (cts) begin
          m_phase = 2;
          m_cnt   = 0;
        end else begin
          m_cnt++;
`ifdef LINK_ARB_TIMEOUT_EN
          if (m_cnt == TO) begin
            m_phase = 4;
            exp_q.push_back('{m_id, m_data, 1'b1});
          end
`endif
        end
        2: if (!cts) begin
          m_phase = 3;
          exp_q.push_back('{m_id, m_data, 1'b0});
        end else begin
          m_cnt++;
`ifdef LINK_ARB_TIMEOUT_EN
          if (m_cnt == TO) begin
            m_phase = 4;
            exp_q.push_back('{m_id, m_data, 1'b1});
          end
`endif
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  dchk_t mon_d;
  exp_t  mon_e;
  int    want_line, got_line, want_ack, want_err;

  task automatic mon_cmp(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (dq.size() > 0) begin
      mon_d = dq.pop_front();
      mon_cmp(mon_d.name, mon_d.got, mon_d.want);
    end
    if (!rst) begin
      got_line  = int'({rts, busy});
      want_line = ((m_phase == 1) ? 2 : 0) + ((m_phase != 0) ? 1 : 0);
      mon_cmp("line_rts_busy", got_line, want_line);
      if (m_phase == 3 || m_phase == 4 || ack != '0 || err != '0) begin
        if (exp_q.size() == 0) begin
          mon_cmp("unexpected_pulse", int'({ack, err}), 0);
        end else begin
          mon_e    = exp_q.pop_front();
          want_ack = mon_e.is_err ? 0 : (1 << mon_e.id);
          want_err = mon_e.is_err ? (1 << mon_e.id) : 0;
          mon_cmp("sb_ack", int'(ack), want_ack);
          mon_cmp("sb_err", int'(err), want_err);
          mon_cmp("sb_grant_id", int'(grant_id), mon_e.id);
          mon_cmp("sb_v_out", int'(v_out), mon_e.data);
          if (ack != '0) ack_log.push_back(int'(grant_id));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int mode = 0;      // 0 manual, 1 random, 2 always re-raise, 3 drain
  bit cts_auto = 1'b0;
  bit cts_rand = 1'b0;
  int cts_dly = 0;
  int cts_cnt = 0;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    dq.push_back('{name, got, want});
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    logic [N*DW-1:0] m;
    m = {{(N*DW-DW){1'b0}}, {DW{1'b1}}} << (i * DW);
    req_data = (req_data & ~m) | ({{(N*DW-DW){1'b0}}, v} << (i * DW));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (bit_of(req, i) && (bit_of(ack, i) || bit_of(err, i))) begin
        req = req & ~(N'(1) << i);
      end else if (!bit_of(req, i)) begin
        if (mode == 2 || (mode == 1 && $urandom_range(0, 3) == 0)) begin
          set_word(i, DW'($urandom_range(0, 15)));
          req = req | (N'(1) << i);
        end
      end else if (mode == 1 && $urandom_range(0, 7) == 0) begin
        set_word(i, DW'($urandom_range(0, 15)));
      end
    end
  endtask

  task automatic drive_cts();
    if (cts_auto) begin
      if (rts != cts) begin
        if (cts_cnt >= cts_dly) begin
          cts     = rts;
          cts_cnt = 0;
          if (cts_rand) cts_dly = int'($urandom_range(0, 3));
        end else begin
          cts_cnt++;
        end
      end else begin
        cts_cnt = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_reqs();
    drive_cts();
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int maxc);
    int c;
    c = 0;
    while (ack == '0 && err == '0 && c < maxc) begin
      step();
      c++;
    end
    chk(name, int'(ack != '0 || err != '0), 1);
  endtask

  initial begin
    int base, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rts", int'(rts), 0);
    chk("rst_v_out", int'(v_out), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    rst = 1'b0;

    // single request, cts answers after a delay
    step();
    cts_auto = 1'b1; cts_dly = 2;
    set_word(0, 4'hA); req = 4'b0001;
    step();
    chk("t1_rts_latency", int'(rts), 1);
    chk("t1_v_out", int'(v_out), 'hA);
    chk("t1_grant_id", int'(grant_id), 0);
    wait_ack("t1_ack_seen", 40);
    chk("t1_ack", int'(ack), 1);
    chk("t1_v_out_done", int'(v_out), 'hA);
    step();
    chk("t1_ack_one_cycle", int'(ack), 0);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_v_out_hold", int'(v_out), 'hA);

    // all four requesting continuously: grant order 0,1,2,3,0
    do_reset();
    cts_auto = 1'b1; cts_dly = 0; cts_rand = 1'b0;
    mode = 2;
    base = ack_log.size();
    n = 0;
    while (ack_log.size() < base + 5 && n < 300) begin
      step();
      n++;
    end
    mode = 3;
    chk("t2_acks_seen", int'(ack_log.size() >= base + 5), 1);
    for (int j = 0; j < 5; j++) begin
      if (base + j < ack_log.size()) chk("t2_grant_order", ack_log[base + j], j % N);
    end
    n = 0;
    while ((req != '0 || busy) && n < 100) begin
      step();
      n++;
    end
    chk("t2_drain", int'(req == '0 && !busy), 1);

    // cts already high before the grant
    do_reset();
    mode = 0; cts_auto = 1'b0; cts = 1'b1;
    repeat (3) step();
    chk("t3_idle_cts_ignored", int'(busy), 0);
    set_word(0, 4'h5); req = 4'b0001;
    step();
    chk("t3_send_entered", int'(rts), 1);
    step();
    chk("t3_send_one_cycle", int'(rts), 0);
    chk("t3_busy_release", int'(busy), 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t3_release_hold", int'(ack), 0);
    end
    cts = 1'b0;
    step();
    chk("t3_ack_after_cts_low", int'(ack), 1);
    step();
    chk("t3_ack_cleared", int'(ack), 0);

    // reset in the middle of SEND, then pointer restart
    do_reset();
    cts = 1'b0;
    set_word(0, 4'h9); req = 4'b0001;
    step();
    chk("t4_send", int'(rts), 1);
    rst = 1'b1;
    #1;
    chk("t4_rst_rts", int'(rts), 0);
    chk("t4_rst_v_out", int'(v_out), 0);
    chk("t4_rst_ack", int'(ack), 0);
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_grant", int'(grant_id), 0);
    req = '0;
    step();
    rst = 1'b0;
    set_word(2, 4'h7); req = 4'b0100;
    step();
    chk("t4_lone_req2", int'(grant_id), 2);
    cts_auto = 1'b1; cts_dly = 0;
    wait_ack("t4_ack2_seen", 20);
    chk("t4_ack2", int'(ack), 4);
    step();
    do_reset();
    set_word(1, 4'h1); set_word(2, 4'h2); req = 4'b0110;
    step();
    chk("t4_restart_winner", int'(grant_id), 1);
    wait_ack("t4_ack1_seen", 20);
    chk("t4_ack1", int'(ack), 2);
    step();
    wait_ack("t4_ack2b_seen", 20);
    chk("t4_ack2b", int'(ack), 4);
    step();

    // req_data change during RELEASE is ignored
    do_reset();
    cts_auto = 1'b0; cts = 1'b0;
    set_word(0, 4'h3); req = 4'b0001;
    step();
    chk("t6_send_v_out", int'(v_out), 3);
    cts = 1'b1;
    step();
    chk("t6_release", int'(rts), 0);
    set_word(0, 4'hC);
    step();
    chk("t6_v_out_a", int'(v_out), 3);
    step();
    chk("t6_v_out_b", int'(v_out), 3);
    cts = 1'b0;
    step();
    chk("t6_ack", int'(ack), 1);
    chk("t6_v_out_done", int'(v_out), 3);
    step();
    chk("t6_v_out_idle", int'(v_out), 3);

`ifdef LINK_ARB_TIMEOUT_EN
    // cts stuck low: abort after TO SEND cycles, next requester served
    do_reset();
    cts_auto = 1'b0; cts = 1'b0;
    set_word(0, 4'h1); set_word(1, 4'h2); req = 4'b0011;
    step();
    n = 0;
    while (rts && n < 40) begin
      n++;
      step();
    end
    chk("to_send_cycles", n, TO);
    chk("to_err", int'(err), 1);
    chk("to_no_ack", int'(ack), 0);
    cts_auto = 1'b1; cts_dly = 0;
    step();
    wait_ack("to_next_seen", 20);
    chk("to_next_ack", int'(ack), 2);
    step();
`endif

    // randomized traffic
    do_reset();
    mode = 1; cts_auto = 1'b1; cts_rand = 1'b1; cts_dly = 1;
    repeat (3000) step();
    mode = 3;
    n = 0;
    while ((req != '0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk("rand_drain", int'(req == '0 && !busy), 1);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
